evt_window_ctrl: RTL and testbench



---
 rtl/evt_window_pkg.sv | 18 +
 rtl/evt_window_ctrl_win_timer.sv | 36 +++
 rtl/evt_window_ctrl.sv | 135 +++++++++++++
 tb/tb_evt_window_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/evt_window_pkg.sv
// Shared types, widths and helpers for the windowed event-rate controller.
package evt_window_pkg;

    typedef enum logic [1:0] {StIdle, StArm, StCount} state_e;

    localparam int unsigned DEF_MAX_COUNT = 512;
    localparam int unsigned CNT_W = $clog2(DEF_MAX_COUNT) + 1;

    // Increment by inc, never exceeding max_val.
    function automatic int unsigned sat_inc(input int unsigned cnt, input logic inc,
                                            input int unsigned max_val);
        if (!inc || cnt >= max_val) begin
            return cnt;
        end
        return cnt + 1;
    endfunction

endpackage

// File: rtl/evt_window_ctrl_win_timer.sv
// Loadable down-counter; last flags the final cycle of a window.
module win_timer #(
    parameter int unsigned WinW = 27
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            dec,
    input  logic [WinW-1:0] len,
    output logic            last
);

    localparam logic [WinW-1:0] One = WinW'(1);

    logic [WinW-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (load) begin
            timer_d = (len == '0) ? One : len;
        end else if (dec && timer_q != '0) begin
            timer_d = timer_q - One;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign last = (timer_q == One);

endmodule

// File: rtl/evt_window_ctrl.sv
// Gates an event strobe into back-to-back fixed-length windows and publishes
// each window's saturated count on a valid/ready output.
module evt_window_ctrl
    import evt_window_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 512,
    parameter int unsigned WIN_W     = 27
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [WIN_W-1:0]           window_len,
    input  logic                       evt,
    input  logic                       clr_ovr,
    output logic [$clog2(MAX_COUNT):0] rate_data,
    output logic                       rate_valid,
    input  logic                       rate_ready,
    output logic [7:0]                 win_seq,
    output logic                       busy,
    output logic                       overrun
);

    localparam int unsigned CntW = $clog2(MAX_COUNT) + 1;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] rate_data_q, rate_data_d;
    logic            rate_valid_q, rate_valid_d;
    logic [7:0]      win_seq_q, win_seq_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic [CntW-1:0] count_inc;
    logic            tmr_load, tmr_dec, tmr_last;

    assign count_inc = CntW'(sat_inc(32'(count_q), evt, MAX_COUNT));

    win_timer #(
        .WinW(WIN_W)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (tmr_load),
        .dec  (tmr_dec),
        .len  (window_len),
        .last (tmr_last)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rate_data_d  = rate_data_q;
        rate_valid_d = rate_valid_q;
        win_seq_d    = win_seq_q;
        overrun_d    = overrun_q;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;

        if (rate_valid_q && rate_ready) begin
            rate_valid_d = 1'b0;
        end
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                count_d = '0;
                if (enable) begin
                    tmr_load = 1'b1;
                    state_d  = StCount;
                end else begin
                    state_d = StIdle;
                end
            end
            StCount: begin
                if (tmr_last) begin
                    // Terminal event belongs to the ending window; reload for zero-gap restart.
                    rate_data_d  = count_inc;
                    rate_valid_d = 1'b1;
                    win_seq_d    = win_seq_q + 8'd1;
                    if (rate_valid_q && !rate_ready) begin
                        overrun_d = 1'b1;
                    end
                    count_d = '0;
                    if (enable) begin
                        tmr_load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (!enable) begin
                    count_d = '0;
                    state_d = StIdle;
                end else begin
                    count_d = count_inc;
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            count_q      <= '0;
            rate_data_q  <= '0;
            rate_valid_q <= 1'b0;
            win_seq_q    <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rate_data_q  <= rate_data_d;
            rate_valid_q <= rate_valid_d;
            win_seq_q    <= win_seq_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rate_data  = rate_data_q;
    assign rate_valid = rate_valid_q;
    assign win_seq    = win_seq_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_evt_window_ctrl.sv
// Directed bench for evt_window_ctrl with MAX_COUNT=8 so saturation is reachable.
module tb_evt_window_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [26:0] window_len;
    logic        evt;
    logic        clr_ovr;
    logic [3:0]  rate_data;
    logic        rate_valid;
    logic        rate_ready;
    logic [7:0]  win_seq;
    logic        busy;
    logic        overrun;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    evt_window_ctrl #(
        .MAX_COUNT(8),
        .WIN_W    (27)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .window_len(window_len),
        .evt       (evt),
        .clr_ovr   (clr_ovr),
        .rate_data (rate_data),
        .rate_valid(rate_valid),
        .rate_ready(rate_ready),
        .win_seq   (win_seq),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic p1w [4];
        p1w = '{1'b1, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0; enable = 1'b0; window_len = 27'd10; evt = 1'b0;
        clr_ovr = 1'b0; rate_ready = 1'b0;
        tick(); tick();
        check("rst_data", rate_data, 0);
        check("rst_valid", rate_valid, 0);
        check("rst_seq", win_seq, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;

        // Window of 10, events in COUNT cycles 2,5,7,10 plus one in ARM (ignored).
        enable = 1'b1;
        tick();
        check("arm_busy", busy, 1);
        evt = 1'b1;
        tick();
        for (int c = 1; c <= 10; c++) begin
            evt = (c == 2 || c == 5 || c == 7 || c == 10);
            if (c == 10) enable = 1'b0;
            tick();
            if (c == 9) check("w10_early_valid", rate_valid, 0);
        end
        evt = 1'b0;
        check("w10_valid", rate_valid, 1);
        check("w10_data", rate_data, 4);
        check("w10_seq", win_seq, 1);
        check("w10_idle", busy, 0);
        tick();
        check("hold_valid", rate_valid, 1);
        check("hold_data", rate_data, 4);
        rate_ready = 1'b1;
        tick();
        check("consume_valid", rate_valid, 0);
        check("consume_data", rate_data, 4);

        // Back-to-back windows of 5 with evt held high.
        window_len = 27'd5; evt = 1'b1; enable = 1'b1;
        tick();
        tick();
        for (int w = 0; w < 3; w++) begin
            for (int t = 1; t <= 5; t++) begin
                tick();
                check("b2b_valid", rate_valid, (t == 5) ? 1 : 0);
                if (t == 5) begin
                    check("b2b_data", rate_data, 5);
                    check("b2b_seq", win_seq, 2 + w);
                end
            end
        end
        // Mid-window length change applies only from the next window.
        window_len = 27'd20;
        for (int t = 1; t <= 5; t++) begin
            tick();
            check("midchg_valid", rate_valid, (t == 5) ? 1 : 0);
        end
        check("midchg_data", rate_data, 5);
        check("midchg_seq", win_seq, 5);
        for (int t = 1; t <= 20; t++) begin
            if (t == 20) enable = 1'b0;
            tick();
            if (t == 19) check("sat_early_valid", rate_valid, 0);
        end
        check("sat_data", rate_data, 8);
        check("sat_seq", win_seq, 6);
        check("sat_idle", busy, 0);
        check("b2b_no_ovr", overrun, 0);
        tick();
        check("sat_consumed", rate_valid, 0);

        // Overrun: two publishes with no consumer.
        window_len = 27'd3; rate_ready = 1'b0; evt = 1'b0; enable = 1'b1;
        tick();
        tick();
        for (int c = 1; c <= 3; c++) begin
            evt = (c == 1);
            tick();
        end
        check("ovA_data", rate_data, 1);
        check("ovA_ovr", overrun, 0);
        check("ovA_seq", win_seq, 7);
        for (int c = 1; c <= 3; c++) begin
            evt = (c <= 2);
            enable = (c != 3);
            tick();
        end
        evt = 1'b0;
        check("ovB_data", rate_data, 2);
        check("ovB_valid", rate_valid, 1);
        check("ovB_ovr", overrun, 1);
        check("ovB_seq", win_seq, 8);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("clr_ovr", overrun, 0);
        check("clr_keeps_valid", rate_valid, 1);

        // Consumer accepts in the same cycle as a publish: no overrun.
        window_len = 27'd2; enable = 1'b1; evt = 1'b1;
        tick();
        tick();
        tick();
        evt = 1'b0; rate_ready = 1'b1; enable = 1'b0;
        tick();
        check("same_data", rate_data, 1);
        check("same_valid", rate_valid, 1);
        check("same_ovr", overrun, 0);
        check("same_seq", win_seq, 9);
        tick();
        check("same_consumed", rate_valid, 0);

        // Abort in cycle 3 of 10.
        window_len = 27'd10; enable = 1'b1; evt = 1'b1; rate_ready = 1'b0;
        tick();
        tick();
        tick();
        tick();
        enable = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_valid", rate_valid, 0);
        check("abort_seq", win_seq, 9);
        tick();
        check("abort_stay_valid", rate_valid, 0);
        window_len = 27'd2; enable = 1'b1;
        tick();
        check("rearm_busy", busy, 1);
        tick();
        evt = 1'b0;
        tick();
        evt = 1'b1; enable = 1'b0;
        tick();
        evt = 1'b0;
        check("rearm_data", rate_data, 1);
        check("rearm_seq", win_seq, 10);
        check("rearm_valid", rate_valid, 1);

        // Reset during COUNT with a pending result.
        window_len = 27'd4; enable = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mrst_data", rate_data, 0);
        check("mrst_valid", rate_valid, 0);
        check("mrst_seq", win_seq, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ovr", overrun, 0);
        rst_n = 1'b1; enable = 1'b0;
        tick();

        // window_len=0 behaves as 1-cycle windows.
        window_len = 27'd0; enable = 1'b1; rate_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            evt = p1w[i];
            tick();
            check("w0_valid", rate_valid, 1);
            check("w0_data", rate_data, {31'd0, p1w[i]});
            check("w0_seq", win_seq, i + 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
